mem_arbiter: RTL

Two-master, one-slave arbiter that shares the single memory-controller burst port between the data cache (master D) and the instruction cache (master I). It sits between both caches and the memory controller. It holds a grant for a whole block burst, from request through the controller's `mem_last` beat. It inserts a one-cycle bus-idle gap between bursts, so the controller always sees a fresh `mem_enable` assertion. Arbitration is round-robin or fixed data-cache priority, selected by parameter.

---
 rtl/mem_arbiter.sv | 76 +++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master burst arbiter (data cache D, instruction cache I) onto one memory-controller port.
module mem_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] d_mem_addr,
  input  logic                  d_mem_enable,
  input  logic                  d_mem_rw,
  input  logic [DATA_WIDTH-1:0] d_mem_write,
  output logic [DATA_WIDTH-1:0] d_mem_read,
  output logic                  d_mem_read_valid,
  output logic                  d_mem_write_req,
  output logic                  d_mem_last,
  input  logic [ADDR_WIDTH-1:0] i_mem_addr,
  input  logic                  i_mem_enable,
  output logic [DATA_WIDTH-1:0] i_mem_read,
  output logic                  i_mem_read_valid,
  output logic                  i_mem_last,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_enable,
  output logic                  mem_rw,
  output logic [DATA_WIDTH-1:0] mem_write,
  input  logic [DATA_WIDTH-1:0] mem_read,
  input  logic                  mem_read_valid,
  input  logic                  mem_write_req,
  input  logic                  mem_last,
  output logic                  grant_d,
  output logic                  grant_i,
  output logic                  busy
);
  localparam logic MEM_READ = 1'b0;
  typedef enum logic [1:0] {IDLE, GRANT_D, GRANT_I, GAP} state_t;
  state_t state_q, state_d;
  logic   last_d_q, last_d_d;
  logic   pick_d;
  always_comb begin
    pick_d   = d_mem_enable && (!i_mem_enable || PRIORITY_MODE != 0 || !last_d_q);
    state_d  = state_q;
    last_d_d = last_d_q;
    case (state_q)
      IDLE, GAP: begin
        state_d  = pick_d ? GRANT_D : i_mem_enable ? GRANT_I : IDLE;
        last_d_d = pick_d ? 1'b1 : i_mem_enable ? 1'b0 : last_d_q;
      end
      GRANT_D: state_d = (mem_last || !d_mem_enable) ? GAP : GRANT_D;
      GRANT_I: state_d = (mem_last || !i_mem_enable) ? GAP : GRANT_I;
    endcase
  end
  // last_d_q low after reset: I counts as last owner, so D wins the first conflict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end
  assign grant_d          = state_q == GRANT_D;
  assign grant_i          = state_q == GRANT_I;
  assign busy             = grant_d | grant_i;
  assign mem_addr         = grant_d ? d_mem_addr : grant_i ? i_mem_addr : '0;
  assign mem_enable       = grant_d ? d_mem_enable : grant_i & i_mem_enable;
  assign mem_rw           = grant_d ? d_mem_rw : MEM_READ;
  assign mem_write        = grant_d ? d_mem_write : '0;
  assign d_mem_read       = mem_read;
  assign i_mem_read       = mem_read;
  assign d_mem_read_valid = grant_d & mem_read_valid;
  assign d_mem_write_req  = grant_d & mem_write_req;
  assign d_mem_last       = grant_d & mem_last;
  assign i_mem_read_valid = grant_i & mem_read_valid;
  assign i_mem_last       = grant_i & mem_last;
endmodule
